// File: rtl/circle_seg7_pkg.sv
// Shared types and segment patterns for the running-circle 7-segment animation.
package circle_seg7_pkg;

    typedef logic [7:0] seg7_t;

    // Segment patterns in {dp,g,f,e,d,c,b,a} order, 1 = lit
    localparam seg7_t SEG_A   = 8'h01;
    localparam seg7_t SEG_D   = 8'h08;
    localparam seg7_t SEG_OFF = 8'h00;

endpackage

// File: rtl/circle_seg7_if.sv
// Bundle of the animation's direction input and display-side outputs.
// The animation core is the master; the pin driver / observer is the slave.
interface circle_seg7_if
    import circle_seg7_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int NUM_DISPLAYS = 6,
    parameter int COL_WIDTH    = 6,
    parameter int DISP_W       = $clog2(NUM_DISPLAYS)
) ();

    logic                           sens_i;
    logic [WIDTH-1:0]               count_o;
    logic                           overflow_o;
    logic                           row_o;
    logic [COL_WIDTH-1:0]           column_o;
    logic [DISP_W-1:0]              curr_display_o;
    logic                           directie_o;
    seg7_t [NUM_DISPLAYS-1:0]       seg7_o;

    modport master (
        input  sens_i,
        output count_o,
        output overflow_o,
        output row_o,
        output column_o,
        output curr_display_o,
        output directie_o,
        output seg7_o
    );

    modport slave (
        output sens_i,
        input  count_o,
        input  overflow_o,
        input  row_o,
        input  column_o,
        input  curr_display_o,
        input  directie_o,
        input  seg7_o
    );

endinterface

// File: rtl/circle_seg7_prescaler.sv
// Free-running prescaler: counts 0..COUNT_TO and flags the terminal value
// as the animation step tick.
module circle_seg7_prescaler #(
    parameter int WIDTH    = 4,
    parameter int COUNT_TO = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [WIDTH-1:0] count_o,
    output logic             overflow_o
);

    // Tick is high for the whole cycle the counter sits on its terminal value
    assign overflow_o = (count_o == WIDTH'(COUNT_TO));

    // Count up, wrapping to zero right after the tick cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_o <= '0;
        end else if (overflow_o) begin
            count_o <= '0;
        end else begin
            count_o <= count_o + WIDTH'(1);
        end
    end

endmodule

// File: rtl/circle_seg7_top.sv
// Running-circle animation: one lit segment walks along the top row (seg a)
// and back along the bottom row (seg d), one step per prescaler tick.
module circle_seg7_top
    import circle_seg7_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int COUNT_TO     = 9,
    parameter int NUM_DISPLAYS = 6,
    parameter int COL_WIDTH    = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    circle_seg7_if.master bus
);

    localparam int DISP_W = $clog2(NUM_DISPLAYS);
    localparam int POS_W  = $clog2(2 * NUM_DISPLAYS);

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(2 * NUM_DISPLAYS - 1);
    localparam logic [POS_W-1:0] POS_ROW  = POS_W'(NUM_DISPLAYS);

    logic             tick;
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] mirror;
    logic             top_row;
    logic [DISP_W-1:0] curr_display;

    circle_seg7_prescaler #(
        .WIDTH    (WIDTH),
        .COUNT_TO (COUNT_TO)
    ) u_prescaler (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .count_o    (bus.count_o),
        .overflow_o (tick)
    );

    assign bus.overflow_o = tick;

    // Ring position: steps once per tick, direction taken from sens_i at that edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pos <= '0;
        end else if (tick) begin
            if (!bus.sens_i) begin
                pos <= (pos == POS_LAST) ? '0 : pos + POS_W'(1);
            end else begin
                pos <= (pos == '0) ? POS_LAST : pos - POS_W'(1);
            end
        end
    end

    // Fold the ring position into a row and a display index (bottom row runs backwards)
    always_comb begin
        mirror       = POS_LAST - pos;
        top_row      = (pos < POS_ROW);
        curr_display = top_row ? pos[DISP_W-1:0] : mirror[DISP_W-1:0];
    end

    assign bus.row_o          = top_row;
    assign bus.curr_display_o = curr_display;
    assign bus.directie_o     = (~top_row) ^ bus.sens_i;

    // Fan the single lit segment out to the active display and its column strobe
    always_comb begin
        bus.column_o = '0;
        for (int i = 0; i < NUM_DISPLAYS; i++) begin
            bus.seg7_o[i] = SEG_OFF;
            if (curr_display == DISP_W'(i)) begin
                bus.seg7_o[i]   = top_row ? SEG_A : SEG_D;
                bus.column_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_circle_seg7_top.sv
// Self-checking bench for circle_seg7_top: behavioural ring model checked every
// cycle, plus directed literal checks of reset, first step and leg order.
module tb_circle_seg7_top;

    localparam int WIDTH        = 4;
    localparam int COUNT_TO     = 9;
    localparam int NUM_DISPLAYS = 6;
    localparam int COL_WIDTH    = 6;
    localparam int RING         = 2 * NUM_DISPLAYS;

    logic clk;
    logic rst;

    int total;
    int bad;

    // Model state: plain integers for the prescaler value and ring position
    int model_count;
    int model_pos;
    bit model_valid;

    circle_seg7_if #(
        .WIDTH        (WIDTH),
        .NUM_DISPLAYS (NUM_DISPLAYS),
        .COL_WIDTH    (COL_WIDTH)
    ) bus ();

    circle_seg7_top #(
        .WIDTH        (WIDTH),
        .COUNT_TO     (COUNT_TO),
        .NUM_DISPLAYS (NUM_DISPLAYS),
        .COL_WIDTH    (COL_WIDTH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs a little after a rising edge so they are stable at the next one
    task automatic applyStimulus(input logic r, input logic s);
        @(posedge clk);
        #2;
        rst        = r;
        bus.sens_i = s;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model advanced on each rising edge from the specified stepping rules
    always @(posedge clk) begin
        if (rst) begin
            model_count = 0;
            model_pos   = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (model_count == COUNT_TO) begin
                model_count = 0;
                if (bus.sens_i == 1'b0) model_pos = (model_pos + 1) % RING;
                else                    model_pos = (model_pos + RING - 1) % RING;
            end else begin
                model_count = model_count + 1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (model_valid) begin
            int exp_disp;
            bit exp_row;
            logic [8*NUM_DISPLAYS-1:0] exp_seg;
            exp_row  = (model_pos < NUM_DISPLAYS);
            exp_disp = exp_row ? model_pos : (RING - 1 - model_pos);
            exp_seg  = '0;
            exp_seg[exp_disp*8 +: 8] = exp_row ? 8'h01 : 8'h08;
            checkOutput("count",    64'(bus.count_o),        64'(model_count));
            checkOutput("overflow", 64'(bus.overflow_o),     64'(model_count == COUNT_TO));
            checkOutput("row",      64'(bus.row_o),          64'(exp_row));
            checkOutput("display",  64'(bus.curr_display_o), 64'(exp_disp));
            checkOutput("column",   64'(bus.column_o),       64'(1) << exp_disp);
            checkOutput("directie", 64'(bus.directie_o),     64'((!exp_row) ^ bus.sens_i));
            checkOutput("seg7",     64'(bus.seg7_o),         64'(exp_seg));
            checkOutput("seg_onehot", 64'($countones(bus.seg7_o)), 64'(1));
            checkOutput("col_onehot", 64'($countones(bus.column_o)), 64'(1));
        end
    end

    initial begin
        int cycles;
        int exp_disp [13];
        int exp_row  [13];

        exp_disp = '{0, 1, 2, 3, 4, 5, 5, 4, 3, 2, 1, 0, 0};
        exp_row  = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1};
        total       = 0;
        bad         = 0;
        model_valid = 1'b0;
        rst         = 1'b1;
        bus.sens_i  = 1'b0;

        // Reset held, then released: values right after release
        applyStimulus(1'b1, 1'b0);
        repeat (3) @(posedge clk);
        applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        checkOutput("rst_count",  64'(bus.count_o),   64'd0);
        checkOutput("rst_row",    64'(bus.row_o),     64'd1);
        checkOutput("rst_column", 64'(bus.column_o),  64'b000001);
        checkOutput("rst_seg0",   64'(bus.seg7_o[0]), 64'h01);
        checkOutput("rst_dir",    64'(bus.directie_o), 64'd0);

        // First step lands exactly ten edges after release
        cycles = 0;
        while (bus.curr_display_o != 1 && cycles < 50) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        checkOutput("first_step_cycles", 64'(cycles), 64'd10);
        checkOutput("first_step_count",  64'(bus.count_o), 64'd0);

        // Full clockwise lap: top leg then bottom leg then home
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        for (int t = 0; t < 13; t++) begin
            if (t != 0) repeat (10) @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("lap_disp%0d", t), 64'(bus.curr_display_o), 64'(exp_disp[t]));
            checkOutput($sformatf("lap_row%0d", t),  64'(bus.row_o),          64'(exp_row[t]));
            checkOutput($sformatf("lap_seg%0d", t),  64'(bus.seg7_o[exp_disp[t]]),
                        (exp_row[t] != 0) ? 64'h01 : 64'h08);
        end

        // Counter-clockwise from reset: first tick wraps to the bottom row
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("ccw_row",  64'(bus.row_o),          64'd0);
        checkOutput("ccw_disp", 64'(bus.curr_display_o), 64'd0);
        checkOutput("ccw_seg0", 64'(bus.seg7_o[0]),      64'h08);
        checkOutput("ccw_dir",  64'(bus.directie_o),     64'd0);

        // Direction change mid-interval waits for the next tick; reset mid-run
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        repeat (13) @(posedge clk);
        applyStimulus(1'b0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("toggle_hold_disp", 64'(bus.curr_display_o), 64'd1);
        checkOutput("toggle_hold_dir",  64'(bus.directie_o),     64'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("toggle_step_disp", 64'(bus.curr_display_o), 64'd0);
        checkOutput("toggle_step_row",  64'(bus.row_o),          64'd1);
        applyStimulus(1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_count", 64'(bus.count_o),        64'd0);
        checkOutput("midrst_disp",  64'(bus.curr_display_o), 64'd0);

        // Randomized direction flips and occasional resets, checked by the model
        for (int i = 0; i < 800; i++) begin
            logic r;
            logic s;
            r = ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 7) == 0) ? ~bus.sens_i : bus.sens_i;
            applyStimulus(r, s);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
